// File: rtl/edsac_ctrl_pkg.sv
// Shared control-section definitions: short order word geometry and the
// tank-select front-end state encoding.
package edsac_ctrl_pkg;

  localparam int WORD_BITS   = 17;
  localparam int MINOR_CYCLE = 18;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ARMED = 2'd2,
    XFER  = 2'd3
  } state_e;

endpackage

// File: rtl/minor_cycle_counter.sv
// Digit-slot counter for one minor cycle; minor_sync forces slot 0 and a sync
// arriving while the count is away from slot 0 is flagged as early.
module minor_cycle_counter #(
  parameter int MINOR_CYCLE = 18,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             minor_sync,
  output logic [CNT_W-1:0] slot,
  output logic             early_sync
);

  logic [CNT_W-1:0] slot_q;

  assign slot       = minor_sync ? '0 : slot_q;
  assign early_sync = minor_sync && (slot_q != '0);

  // Free-runs and wraps when sync is missing; sync is not required to keep time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else if (slot == CNT_W'(MINOR_CYCLE - 1)) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot + 1'b1;
    end
  end

endmodule

// File: rtl/order_select_latch_r2_up.sv
// r2_up tank-select front end: deserialises a short order, latches the two
// select bits as complementary rails and issues one-minor-cycle transfer strobes.
module order_select_latch_r2_up #(
  parameter int WORD_BITS   = edsac_ctrl_pkg::WORD_BITS,
  parameter int MINOR_CYCLE = edsac_ctrl_pkg::MINOR_CYCLE,
  parameter int SEL_LO      = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic minor_sync,
  input  logic order_bit,
  input  logic load_order,
  input  logic xfer_req,
  input  logic dir_in,
  output logic r2_up_f7_pos,
  output logic r2_up_f7_neg,
  output logic r2_up_f8_pos,
  output logic r2_up_f8_neg,
  output logic r2_up_t_in,
  output logic r2_up_t_out,
  output logic order_valid,
  output logic xfer_done,
  output logic frame_err
);
  import edsac_ctrl_pkg::*;

  localparam int CNT_W = $clog2(MINOR_CYCLE + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] slot, strobe_cnt_q, cnt_d;
  logic             early_sync, load_acc, start, abort;
  logic             pending_q, pending_d, order_valid_q, valid_d;
  logic             frame_err_q, err_d, xfer_done_q, done_d;
  logic             shift_en, win_en, latch_en, capture_dir;
  logic [1:0]       win_q, sel_q;
  logic             dir_q;

  minor_cycle_counter #(
    .MINOR_CYCLE (MINOR_CYCLE),
    .CNT_W       (CNT_W)
  ) u_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .minor_sync (minor_sync),
    .slot       (slot),
    .early_sync (early_sync)
  );

  assign load_acc = minor_sync && load_order;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pending_q     <= 1'b0;
      order_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      xfer_done_q   <= 1'b0;
      strobe_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      order_valid_q <= valid_d;
      frame_err_q   <= err_d;
      xfer_done_q   <= done_d;
      strobe_cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    valid_d     = order_valid_q;
    err_d       = frame_err_q;
    done_d      = 1'b0;
    cnt_d       = strobe_cnt_q;
    shift_en    = 1'b0;
    latch_en    = 1'b0;
    capture_dir = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    case (state_q)
      IDLE:  start = load_acc;
      SHIFT: begin
        shift_en = 1'b1;
        if (minor_sync) begin
          abort = 1'b1;
        end else if (slot == CNT_W'(WORD_BITS - 1)) begin
          latch_en = 1'b1;
          valid_d  = 1'b1;
          state_d  = ARMED;
        end
      end
      ARMED: begin
        if (load_acc) begin
          start = 1'b1;
        end else if (minor_sync && pending_q) begin
          state_d = XFER;
          cnt_d   = CNT_W'(1);
        end else if (xfer_req && !pending_q) begin
          pending_d   = 1'b1;
          capture_dir = 1'b1;
        end
      end
      XFER: begin
        if (early_sync) begin
          abort = 1'b1;
        end else if (strobe_cnt_q == CNT_W'(MINOR_CYCLE)) begin
          done_d    = 1'b1;
          pending_d = 1'b0;
          state_d   = ARMED;
          start     = load_acc;
        end else begin
          cnt_d = strobe_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d   = SHIFT;
      valid_d   = 1'b0;
      pending_d = 1'b0;
      err_d     = 1'b0;
      shift_en  = 1'b1;
    end
    if (abort) begin
      state_d   = IDLE;
      valid_d   = 1'b0;
      pending_d = 1'b0;
      err_d     = 1'b1;
    end
  end

  // Only the two-bit select window is retained; it settles once bit SEL_LO+1 is in.
  assign win_en = shift_en && (slot <= CNT_W'(SEL_LO + 1));

  always_ff @(posedge clk) begin
    if (win_en)      win_q <= {order_bit, win_q[1]};
    if (latch_en)    sel_q <= win_q;
    if (capture_dir) dir_q <= dir_in;
  end

  assign r2_up_f7_pos = order_valid_q &  sel_q[0];
  assign r2_up_f7_neg = order_valid_q & ~sel_q[0];
  assign r2_up_f8_pos = order_valid_q &  sel_q[1];
  assign r2_up_f8_neg = order_valid_q & ~sel_q[1];
  assign r2_up_t_in   = (state_q == XFER) &  dir_q;
  assign r2_up_t_out  = (state_q == XFER) & ~dir_q;
  assign order_valid  = order_valid_q;
  assign xfer_done    = xfer_done_q;
  assign frame_err    = frame_err_q;

endmodule
